// File: rtl/mixer_pump_sequencer.sv
// Valve sequencer for one rotary mixer: fill through both inlets, peristaltic mix, drain.
// state | meaning: IDLE wait for command, FILL inlets open, PUMP ring pump stepping, DRAIN outlet open, DONE completion pulse
module mixer_pump_sequencer #(
  parameter int TICK_W = 16,
  parameter int CYC_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [TICK_W-1:0] cmd_fill_ticks,
  input  logic [TICK_W-1:0] cmd_step_ticks,
  input  logic [CYC_W-1:0]  cmd_cycles,
  input  logic [TICK_W-1:0] cmd_drain_ticks,
  input  logic              abort,
  output logic              valve_in_a,
  output logic              valve_in_b,
  output logic              valve_out,
  output logic [2:0]        pump_valve,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_PUMP,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t            state, state_n;
  logic [TICK_W-1:0] tick_cnt, tick_n;
  logic [2:0]        step_idx, step_n;
  logic [CYC_W-1:0]  rev_cnt, rev_n;
  logic [TICK_W-1:0] step_lat, step_lat_n;
  logic [TICK_W-1:0] drain_lat, drain_lat_n;
  logic [CYC_W-1:0]  cyc_lat, cyc_lat_n;

  logic              ready_n, in_a_n, in_b_n, out_n, busy_n, done_n, aborted_n;
  logic [2:0]        pump_n;

  // Tick counter counts down to zero, so a zero duration still lasts one cycle.
  function automatic logic [TICK_W-1:0] load_ticks(input logic [TICK_W-1:0] t);
    return (t == '0) ? '0 : t - TICK_W'(1);
  endfunction

  function automatic logic [2:0] pump_pattern(input logic [2:0] idx);
    case (idx)
      3'd0:    return 3'b110;
      3'd1:    return 3'b100;
      3'd2:    return 3'b101;
      3'd3:    return 3'b001;
      3'd4:    return 3'b011;
      3'd5:    return 3'b010;
      default: return 3'b111;
    endcase
  endfunction

  always_comb begin
    state_n     = state;
    tick_n      = tick_cnt;
    step_n      = step_idx;
    rev_n       = rev_cnt;
    step_lat_n  = step_lat;
    drain_lat_n = drain_lat;
    cyc_lat_n   = cyc_lat;
    aborted_n   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_n     = ST_FILL;
          tick_n      = load_ticks(cmd_fill_ticks);
          step_lat_n  = cmd_step_ticks;
          drain_lat_n = cmd_drain_ticks;
          cyc_lat_n   = cmd_cycles;
        end
      end
      ST_FILL: begin
        if (abort) begin
          state_n   = ST_IDLE;
          aborted_n = 1'b1;
        end else if (tick_cnt != '0) begin
          tick_n = tick_cnt - TICK_W'(1);
        end else if (cyc_lat == '0) begin
          state_n = ST_DRAIN;
          tick_n  = load_ticks(drain_lat);
        end else begin
          state_n = ST_PUMP;
          tick_n  = load_ticks(step_lat);
          step_n  = 3'd0;
          rev_n   = '0;
        end
      end
      ST_PUMP: begin
        if (abort) begin
          state_n   = ST_IDLE;
          aborted_n = 1'b1;
        end else if (tick_cnt != '0) begin
          tick_n = tick_cnt - TICK_W'(1);
        end else if (step_idx != 3'd5) begin
          step_n = step_idx + 3'd1;
          tick_n = load_ticks(step_lat);
        end else if (rev_cnt == cyc_lat - CYC_W'(1)) begin
          state_n = ST_DRAIN;
          tick_n  = load_ticks(drain_lat);
        end else begin
          step_n = 3'd0;
          rev_n  = rev_cnt + CYC_W'(1);
          tick_n = load_ticks(step_lat);
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          state_n   = ST_IDLE;
          aborted_n = 1'b1;
        end else if (tick_cnt != '0) begin
          tick_n = tick_cnt - TICK_W'(1);
        end else begin
          state_n = ST_DONE;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so the registers show the new phase immediately.
    ready_n = 1'b0;
    in_a_n  = 1'b1;
    in_b_n  = 1'b1;
    out_n   = 1'b1;
    pump_n  = 3'b111;
    busy_n  = (state_n != ST_IDLE);
    done_n  = (state_n == ST_DONE);
    case (state_n)
      ST_IDLE:  ready_n = 1'b1;
      ST_FILL: begin
        in_a_n = 1'b0;
        in_b_n = 1'b0;
        pump_n = 3'b000;
      end
      ST_PUMP:  pump_n = pump_pattern(step_n);
      ST_DRAIN: begin
        out_n  = 1'b0;
        pump_n = 3'b000;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      tick_cnt   <= '0;
      step_idx   <= 3'd0;
      rev_cnt    <= '0;
      step_lat   <= '0;
      drain_lat  <= '0;
      cyc_lat    <= '0;
      cmd_ready  <= 1'b0;
      valve_in_a <= 1'b1;
      valve_in_b <= 1'b1;
      valve_out  <= 1'b1;
      pump_valve <= 3'b111;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      state      <= state_n;
      tick_cnt   <= tick_n;
      step_idx   <= step_n;
      rev_cnt    <= rev_n;
      step_lat   <= step_lat_n;
      drain_lat  <= drain_lat_n;
      cyc_lat    <= cyc_lat_n;
      cmd_ready  <= ready_n;
      valve_in_a <= in_a_n;
      valve_in_b <= in_b_n;
      valve_out  <= out_n;
      pump_valve <= pump_n;
      busy       <= busy_n;
      done       <= done_n;
      aborted    <= aborted_n;
    end
  end

endmodule

// File: tb/tb_mixer_pump_sequencer.sv
// Bench for mixer_pump_sequencer: per-cycle output trace compared against a phase-level model.
module tb_mixer_pump_sequencer;
  localparam int TW = 16;
  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [TW-1:0] fill_t = '0, step_t = '0, drain_t = '0;
  logic [CW-1:0] cyc = '0;
  logic          abort = 1'b0;
  logic          valve_in_a, valve_in_b, valve_out, busy, done, aborted;
  logic [2:0]    pump_valve;

  mixer_pump_sequencer #(.TICK_W(TW), .CYC_W(CW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_fill_ticks(fill_t), .cmd_step_ticks(step_t), .cmd_cycles(cyc),
    .cmd_drain_ticks(drain_t), .abort(abort),
    .valve_in_a(valve_in_a), .valve_in_b(valve_in_b), .valve_out(valve_out),
    .pump_valve(pump_valve), .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  // Vector: {cmd_ready, in_a, in_b, out, pump[2:0], busy, done, aborted}
  localparam logic [9:0] V_IDLE  = {4'b1111, 3'b111, 3'b000};
  localparam logic [9:0] V_RST   = {4'b0111, 3'b111, 3'b000};
  localparam logic [9:0] V_ABT   = {4'b1111, 3'b111, 3'b001};
  localparam logic [9:0] V_FILL  = {4'b0001, 3'b000, 3'b100};
  localparam logic [9:0] V_DRAIN = {4'b0110, 3'b000, 3'b100};
  localparam logic [9:0] V_DONE  = {4'b0111, 3'b111, 3'b110};

  int         n_chk = 0;
  int         n_pass = 0;
  logic [9:0] exp_q[$];
  logic [2:0] pat[6];
  int         pf, ps, pc, pd;

  function automatic logic [9:0] obs_vec();
    return {cmd_ready, valve_in_a, valve_in_b, valve_out, pump_valve, busy, done, aborted};
  endfunction

  function automatic int mx1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, expv);
  endtask

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  // Expected trace, one entry per cycle starting right after the acceptance edge.
  function automatic void build(input int f, input int s, input int c, input int d);
    exp_q.delete();
    repeat (mx1(f)) exp_q.push_back(V_FILL);
    for (int r = 0; r < c; r++)
      for (int st = 0; st < 6; st++)
        repeat (mx1(s)) exp_q.push_back({4'b0111, pat[st], 3'b100});
    repeat (mx1(d)) exp_q.push_back(V_DRAIN);
    exp_q.push_back(V_DONE);
  endfunction

  // kind: 0 none, 1 abort, 2 reset; kill is the trace index during which it is raised.
  task automatic run_cmd(input int f, input int s, input int c, input int d,
                         input int kill, input int kind, input bit hold,
                         input bit abort_acc, input string name);
    int n;
    build(f, s, c, d);
    n = exp_q.size();
    if (kind == 2 && kill >= 0) kill = kill % (n - 1);
    if (kind == 1 && kill >= 0) kill = kill % n;
    if ((kind == 2 && kill >= 0) || (kind == 1 && kill >= 0 && kill < n - 1)) begin
      while (exp_q.size() > kill + 1) void'(exp_q.pop_back());
      exp_q.push_back(kind == 1 ? V_ABT : V_RST);
    end
    cmd_valid = 1'b1;
    fill_t    = TW'(f);
    step_t    = TW'(s);
    cyc       = CW'(c);
    drain_t   = TW'(d);
    abort     = abort_acc;
    for (int i = 0; i < exp_q.size(); i++) begin
      clk_step();
      chk($sformatf("%s[%0d]", name, i), 32'(obs_vec()), 32'(exp_q[i]));
      abort = (kind == 1 && i == kill);
      rst   = (kind == 2 && i == kill);
      if (!hold) cmd_valid = 1'b0;
      else if (i == exp_q.size() - 1) begin
        fill_t = TW'(pf); step_t = TW'(ps); cyc = CW'(pc); drain_t = TW'(pd);
      end else begin
        fill_t = TW'($urandom); step_t = TW'($urandom);
        cyc = CW'($urandom); drain_t = TW'($urandom);
      end
    end
    clk_step();
    chk($sformatf("%s_idle", name), 32'(obs_vec()), 32'(V_IDLE));
  endtask

  initial begin
    pat = '{3'b110, 3'b100, 3'b101, 3'b001, 3'b011, 3'b010};

    rst = 1'b1;
    clk_step();
    chk("reset0", 32'(obs_vec()), 32'(V_RST));
    cmd_valid = 1'b1;
    clk_step();
    chk("reset1", 32'(obs_vec()), 32'(V_RST));
    rst = 1'b0;
    cmd_valid = 1'b0;
    clk_step();
    chk("idle_after_reset", 32'(obs_vec()), 32'(V_IDLE));

    run_cmd(3, 2, 2, 4, -1, 0, 1'b0, 1'b0, "nominal");
    run_cmd(2, 1, 0, 2, -1, 0, 1'b0, 1'b0, "zero_rev");
    run_cmd(0, 0, 1, 0, -1, 0, 1'b0, 1'b0, "zero_ticks");
    run_cmd(3, 2, 2, 4, 21, 1, 1'b0, 1'b0, "abort_pump");
    run_cmd(1, 1, 1, 1, 0, 1, 1'b0, 1'b0, "abort_fill");
    run_cmd(2, 0, 0, 3, 3, 1, 1'b0, 1'b0, "abort_drain");
    run_cmd(1, 0, 0, 1, 2, 1, 1'b0, 1'b0, "abort_in_done");
    run_cmd(2, 1, 1, 1, -1, 0, 1'b0, 1'b1, "abort_at_accept");

    pf = 2; ps = 1; pc = 1; pd = 3;
    run_cmd(3, 2, 1, 2, -1, 0, 1'b1, 1'b0, "backpressure");
    run_cmd(pf, ps, pc, pd, -1, 0, 1'b0, 1'b0, "held_cmd");

    run_cmd(3, 2, 2, 4, 29, 2, 1'b0, 1'b0, "reset_drain");
    run_cmd(1, 0, 4095, 1, -1, 0, 1'b0, 1'b0, "max_cycles");
    run_cmd(0, 65535, 0, 2, -1, 0, 1'b0, 1'b0, "max_step_no_rev");

    for (int k = 0; k < 40; k++) begin
      int f, s, c, d, kind;
      f = $urandom_range(0, 5);
      s = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      d = $urandom_range(0, 5);
      kind = $urandom_range(0, 3);
      if (kind == 3) kind = 0;
      run_cmd(f, s, c, d, (kind == 0) ? -1 : int'($urandom_range(0, 200)), kind,
              1'b0, 1'($urandom_range(0, 1)), $sformatf("rand%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mixer_pump_sequencer.md
Name: mixer_pump_sequencer

Overview:
- Control-side driver for one rotary mixer in the flow netlist: it produces the valve actuation sequence for a two-inlet, one-outlet mixer.
- Sequence per command: fill through both inlets, peristaltic mix for N revolutions, drain through the outlet.
- Commands arrive from the chip-level scheduler over a valid/ready handshake; completion is reported by a single-cycle pulse.
- One instance is placed per mixer on the chip.

Parameters:
- TICK_W, 16, width of the fill, step and drain duration fields, in clock cycles.
- CYC_W, 12, width of the mix revolution count.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_fill_ticks  in  TICK_W  fill duration
- cmd_step_ticks  in  TICK_W  duration of each pump step
- cmd_cycles  in  CYC_W  number of mix revolutions
- cmd_drain_ticks  in  TICK_W  drain duration
- abort  in  1  terminate the current operation
- valve_in_a  out  1  inlet A valve; 1 = actuated (closed)
- valve_in_b  out  1  inlet B valve; 1 = actuated (closed)
- valve_out  out  1  outlet valve; 1 = actuated (closed)
- pump_valve  out  3  ring pump valves [2:0]; 1 = closed
- busy  out  1  FSM not in IDLE
- done  out  1  one-cycle pulse on normal completion
- aborted  out  1  one-cycle pulse on abort

Behaviour:
- Reset values:
  - valve_in_a = valve_in_b = valve_out = 1
  - pump_valve = 3'b111
  - busy = done = aborted = 0
  - cmd_ready = 0 during the reset cycle
  - State = IDLE.
- All outputs are registered.
- FSM states: IDLE, FILL, PUMP, DRAIN, DONE.
- IDLE:
  - cmd_ready = 1; all valves closed.
  - Handshake fires when cmd_valid && cmd_ready at a clock edge. All four command fields are latched on that edge and the FSM moves to FILL.
  - cmd_ready = 0 in every other state; commands are back-pressured and never dropped.
- FILL:
  - in_a = 0, in_b = 0, out = 1, pump = 000.
  - Lasts max(fill_ticks, 1) cycles.
  - Exits to PUMP, or to DRAIN when cycles == 0.
- PUMP:
  - in_a, in_b and out are all 1.
  - Six-step pattern, held for max(step_ticks, 1) cycles per step: 110, 100, 101, 001, 011, 010.
  - Step index wraps 5 -> 0 and the revolution counter increments on each wrap.
  - After cycles revolutions, exits to DRAIN.
  - Total PUMP length = 6 * cycles * max(step_ticks, 1).
- DRAIN:
  - in_a = in_b = 1, out = 0, pump = 000.
  - Lasts max(drain_ticks, 1) cycles, then DONE.
- DONE:
  - All valves closed; done = 1 for exactly 1 cycle; then IDLE.
- Latency: valve outputs reflect FILL in the first cycle after the acceptance edge. cmd_ready returns 1 in the cycle after done.
- busy = 1 in FILL, PUMP, DRAIN and DONE.
- Abort:
  - Sampled in FILL, PUMP or DRAIN.
  - Next cycle: IDLE, all valves closed, aborted = 1 for one cycle, no done pulse.
  - Ignored in IDLE and DONE. In IDLE, cmd_valid together with abort is accepted normally.
- rst mid-operation overrides everything: reset values at the next edge, no done or aborted pulse.
- Counters:
  - Tick counter is TICK_W wide; revolution counter is CYC_W wide.
  - Maximum field values must complete without overflow or early exit.
- Latched command fields are unaffected by input changes while busy.

Test Plan:
- Nominal run:
  - Stimulus: fill = 3, step = 2, cycles = 2, drain = 4, accepted at edge k.
  - Required: FILL outputs in cycles k+1..k+3; PUMP in k+4..k+27 with pattern 110,110,100,100,... repeated twice; DRAIN in k+28..k+31; done = 1 at k+32; cmd_ready = 1 at k+33.
- Zero revolutions:
  - Stimulus: cycles = 0, fill = 2, drain = 2.
  - Required: FILL -> DRAIN directly; pump_valve never shows 110; done 5 cycles after acceptance.
- Zero ticks:
  - Stimulus: fill = step = drain = 0, cycles = 1.
  - Required: each phase and step lasts 1 cycle; done 9 cycles after acceptance.
- Abort during PUMP:
  - Stimulus: abort pulsed during step 3 of revolution 1.
  - Required: next cycle all valves = 1, pump = 111, aborted = 1, busy = 0; done never asserted; a new command is accepted the cycle after that.
- Back-pressure:
  - Stimulus: cmd_valid held high with changing fields while busy.
  - Required: cmd_ready = 0 throughout; the running sequence uses the originally latched values; the held command is accepted in the cycle after done.
- Reset mid-DRAIN:
  - Stimulus: rst = 1 for one cycle during DRAIN.
  - Required: reset values on the next edge; no done or aborted pulse; cmd_ready = 1 the cycle after rst deasserts.
